conv33_window: RTL and testbench

Sliding-window generator that sits directly upstream of the 3x3 convolution calculator. It accepts a raster-scan pixel stream, one pixel per cycle at most, and buffers two full image rows in internal line buffers. For every valid 3x3 neighbourhood it presents nine signed pixels plus a one-cycle enable, and these connect straight to the calculator's data_r_c / conv33_en inputs. Padding is "valid" only (no padding); there is no backpressure, because the downstream stage accepts one window per cycle unconditionally.

---
 rtl/conv33_window.sv | 151 +++++++++++++++
 tb/tb_conv33_window.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv33_window.sv
// rtl/conv33_window.sv - 3x3 sliding-window generator over a raster pixel stream (optional CONV33_WIN_STRIDE2_EN)
module conv33_window #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] pix_in,
    input  logic                         pix_valid,
    input  logic                         sof,
    output logic signed [DATA_WIDTH-1:0] data_0_0,
    output logic signed [DATA_WIDTH-1:0] data_0_1,
    output logic signed [DATA_WIDTH-1:0] data_0_2,
    output logic signed [DATA_WIDTH-1:0] data_1_0,
    output logic signed [DATA_WIDTH-1:0] data_1_1,
    output logic signed [DATA_WIDTH-1:0] data_1_2,
    output logic signed [DATA_WIDTH-1:0] data_2_0,
    output logic signed [DATA_WIDTH-1:0] data_2_1,
    output logic signed [DATA_WIDTH-1:0] data_2_2,
    output logic                         conv33_en,
    output logic                         frame_done,
    output logic                         busy
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] x;
    logic [RW-1:0] y;
    logic          restart;
    logic          accept;
    logic          at_row_end;
    logic          at_last;
    logic          win_ok;

    logic signed [DATA_WIDTH-1:0] win [3][3];
    logic signed [DATA_WIDTH-1:0] lb0 [IMG_W];
    logic signed [DATA_WIDTH-1:0] lb1 [IMG_W];

    // Pixel acceptance and its effective coordinate; sof forces (0,0) so an abort restarts cleanly
    always_comb begin
        restart    = pix_valid && sof;
        accept     = restart || (pix_valid && (state == FILL || state == RUN));
        x          = restart ? '0 : col;
        y          = restart ? '0 : row;
        at_row_end = (x == COL_LAST);
        at_last    = at_row_end && (y == ROW_LAST);
        win_ok     = (y >= RW'(2)) && (x >= CW'(2));
`ifdef CONV33_WIN_STRIDE2_EN
        // y,x >= 2 and even means the window's top-left corner is on an even grid point
        win_ok     = win_ok && !y[0] && !x[0];
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: frame progression, with sof able to restart from any state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (restart) state_nxt = FILL;
            end
            FILL: begin
                if (restart) state_nxt = FILL;
                else if (accept && at_row_end && y == RW'(1)) state_nxt = RUN;
            end
            RUN: begin
                if (restart) state_nxt = FILL;
                else if (accept && at_last) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = restart ? FILL : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from the state
    always_comb begin
        busy       = (state == FILL) || (state == RUN);
        frame_done = (state == DONE);
    end

    // Raster counters, window shift registers and the registered window enable
    always_ff @(posedge clk) begin
        if (!rst) begin
            col       <= '0;
            row       <= '0;
            conv33_en <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            conv33_en <= accept && win_ok;
            if (accept) begin
                col <= at_row_end ? '0 : x + CW'(1);
                if (at_last) begin
                    row <= '0;
                end else if (at_row_end) begin
                    row <= y + RW'(1);
                end else begin
                    row <= y;
                end
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= lb0[x];
                win[1][2] <= lb1[x];
                win[2][2] <= pix_in;
            end
        end
    end

    // Two-row line buffer; contents need no reset because every read column is rewritten before use
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[x] <= lb1[x];
            lb1[x] <= pix_in;
        end
    end

    assign data_0_0 = win[0][0];
    assign data_0_1 = win[0][1];
    assign data_0_2 = win[0][2];
    assign data_1_0 = win[1][0];
    assign data_1_1 = win[1][1];
    assign data_1_2 = win[1][2];
    assign data_2_0 = win[2][0];
    assign data_2_1 = win[2][1];
    assign data_2_2 = win[2][2];

endmodule

// File: tb/tb_conv33_window.sv
// tb/tb_conv33_window.sv - self-checking bench for conv33_window (4x4 and 5x5 instances)
`timescale 1ns/1ps
module tb_conv33_window;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst4 = 1'b0, v4 = 1'b0, s4 = 1'b0;
    logic              rst5 = 1'b0, v5 = 1'b0, s5 = 1'b0;
    logic signed [7:0] p4 = '0, p5 = '0;
    logic signed [7:0] o4 [9];
    logic signed [7:0] o5 [9];
    logic              en4, done4, busy4, en5, done5, busy5;

    conv33_window #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(4)) u4 (
        .clk(clk), .rst(rst4), .pix_in(p4), .pix_valid(v4), .sof(s4),
        .data_0_0(o4[0]), .data_0_1(o4[1]), .data_0_2(o4[2]),
        .data_1_0(o4[3]), .data_1_1(o4[4]), .data_1_2(o4[5]),
        .data_2_0(o4[6]), .data_2_1(o4[7]), .data_2_2(o4[8]),
        .conv33_en(en4), .frame_done(done4), .busy(busy4));

    conv33_window #(.DATA_WIDTH(8), .IMG_W(5), .IMG_H(5)) u5 (
        .clk(clk), .rst(rst5), .pix_in(p5), .pix_valid(v5), .sof(s5),
        .data_0_0(o5[0]), .data_0_1(o5[1]), .data_0_2(o5[2]),
        .data_1_0(o5[3]), .data_1_1(o5[4]), .data_1_2(o5[5]),
        .data_2_0(o5[6]), .data_2_1(o5[7]), .data_2_2(o5[8]),
        .conv33_en(en5), .frame_done(done5), .busy(busy5));

    typedef struct {
        logic [71:0] win;
        int          due;
    } exp_t;

    typedef struct {
        logic       v;
        logic       s;
        logic [7:0] p;
        logic       en;
        int         d00;
        int         d22;
        logic       done;
        logic       busy;
    } vec_t;

    int         n_vec = 0, n_bad = 0, edge_n = 0;
    logic       mon_on = 1'b0;
    int         mact [2], my [2], mx [2], done_due [2], n_win [2], n_done [2];
    logic [7:0] img [2][5][5];
    exp_t       q0 [$];
    exp_t       q1 [$];
    int         got_d00_5 [$];
    vec_t       tbl [18];

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int outp(int d, int i);
        return d ? int'(o5[i]) : int'(o4[i]);
    endfunction

    // Reference: remember the frame as written and cut the window straight out of it
    task automatic model_accept(int d, logic s, logic [7:0] p);
        int   w;
        logic ok;
        exp_t e;
        w = d ? 5 : 4;
        if (s) begin
            my[d] = 0; mx[d] = 0; mact[d] = 1;
        end
        img[d][my[d]][mx[d]] = p;
        ok = (my[d] >= 2) && (mx[d] >= 2);
`ifdef CONV33_WIN_STRIDE2_EN
        ok = ok && ((my[d] - 2) % 2 == 0) && ((mx[d] - 2) % 2 == 0);
`endif
        if (ok) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    e.win[8*(r*3+c) +: 8] = img[d][my[d]-2+r][mx[d]-2+c];
            e.due = edge_n;
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        if (mx[d] == w - 1) begin
            mx[d] = 0;
            if (my[d] == w - 1) begin
                my[d] = 0; mact[d] = 0; done_due[d] = edge_n;
            end else begin
                my[d]++;
            end
        end else begin
            mx[d]++;
        end
    endtask

    task automatic cyc(int d, logic v, logic s, logic [7:0] p);
        if (d == 0) begin
            v4 = v; s4 = s; p4 = p; v5 = 1'b0; s5 = 1'b0;
        end else begin
            v5 = v; s5 = s; p5 = p; v4 = 1'b0; s4 = 1'b0;
        end
        @(posedge clk); #1;
        if (v && (s || mact[d] == 1)) model_accept(d, s, p);
    endtask

    task automatic idle(int d, int n);
        repeat (n) cyc(d, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic do_rst(int d);
        if (d == 0) begin rst4 = 1'b0; v4 = 1'b1; s4 = 1'b0; p4 = 8'sd77; end
        else        begin rst5 = 1'b0; v5 = 1'b1; s5 = 1'b0; p5 = 8'sd77; end
        @(posedge clk); #1;
        mact[d] = 0; done_due[d] = -1;
        if (d == 0) q0.delete(); else q1.delete();
        for (int i = 0; i < 9; i++) chk($sformatf("rst_data_d%0d_%0d", d, i), outp(d, i), 0);
        chk("rst_en",   d ? int'(en5)   : int'(en4),   0);
        chk("rst_done", d ? int'(done5) : int'(done4), 0);
        chk("rst_busy", d ? int'(busy5) : int'(busy4), 0);
        if (d == 0) begin rst4 = 1'b1; v4 = 1'b0; end
        else        begin rst5 = 1'b1; v5 = 1'b0; end
    endtask

    // Scoreboard side: every cycle, compare enable/window/done/busy against what the model predicted
    task automatic mon(int d);
        logic en, dn, bz, exp_now;
        int   have;
        exp_t e;
        en   = d ? en5 : en4;
        dn   = d ? done5 : done4;
        bz   = d ? busy5 : busy4;
        have = d ? q1.size() : q0.size();
        exp_now = 1'b0;
        if (have > 0) begin
            e = d ? q1[0] : q0[0];
            exp_now = (e.due == edge_n);
        end
        if (en || exp_now) begin
            chk($sformatf("window_en_d%0d", d), int'(en), int'(exp_now));
            if (en && exp_now) begin
                for (int i = 0; i < 9; i++)
                    chk($sformatf("window_d%0d_%0d", d, i), outp(d, i), int'($signed(e.win[8*i +: 8])));
                n_win[d]++;
                if (d == 1) got_d00_5.push_back(outp(1, 0));
            end
            if (exp_now) begin
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
        end
        chk($sformatf("frame_done_d%0d", d), int'(dn), int'(done_due[d] == edge_n));
        if (dn) n_done[d]++;
        chk($sformatf("busy_d%0d", d), int'(bz), mact[d]);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            mon(0);
            mon(1);
        end
    end

    initial begin
        int n0, nd;
        for (int d = 0; d < 2; d++) begin
            mact[d] = 0; my[d] = 0; mx[d] = 0; done_due[d] = -1; n_win[d] = 0; n_done[d] = 0;
        end
        do_rst(0);
        do_rst(1);
        mon_on = 1'b1;

        // 4x4 continuous frame, values y*4+x+1
        for (int k = 0; k < 16; k++) begin
            tbl[k].v = 1'b1; tbl[k].s = (k == 0); tbl[k].p = 8'(k + 1);
            tbl[k].en = 1'b0; tbl[k].d00 = 0; tbl[k].d22 = 0;
            tbl[k].done = (k == 15); tbl[k].busy = (k != 15);
        end
        for (int k = 16; k < 18; k++) begin
            tbl[k].v = 1'b0; tbl[k].s = 1'b0; tbl[k].p = 8'd0; tbl[k].en = 1'b0;
            tbl[k].d00 = 0; tbl[k].d22 = 0; tbl[k].done = 1'b0; tbl[k].busy = 1'b0;
        end
        tbl[10].en = 1'b1; tbl[10].d00 = 1; tbl[10].d22 = 11;
        tbl[11].en = 1'b1; tbl[11].d00 = 2; tbl[11].d22 = 12;
        tbl[14].en = 1'b1; tbl[14].d00 = 5; tbl[14].d22 = 15;
        tbl[15].en = 1'b1; tbl[15].d00 = 6; tbl[15].d22 = 16;
        n0 = n_win[0];
        for (int i = 0; i < 18; i++) begin
            cyc(0, tbl[i].v, tbl[i].s, tbl[i].p);
            chk($sformatf("tbl%0d_en", i), int'(en4), int'(tbl[i].en));
            if (tbl[i].en) begin
                chk($sformatf("tbl%0d_d00", i), outp(0, 0), tbl[i].d00);
                chk($sformatf("tbl%0d_d22", i), outp(0, 8), tbl[i].d22);
            end
            chk($sformatf("tbl%0d_done", i), int'(done4), int'(tbl[i].done));
            chk($sformatf("tbl%0d_busy", i), int'(busy4), int'(tbl[i].busy));
        end
        chk("tbl_window_count", n_win[0] - n0, 4);

        // Same frame with two idle cycles between pixels
        n0 = n_win[0];
        for (int k = 0; k < 16; k++) begin
            cyc(0, 1'b1, k == 0, 8'(k + 1));
            if (k < 15) idle(0, 2);
        end
        idle(0, 2);
        chk("gap_window_count", n_win[0] - n0, 4);

        // 5x5: no window for x<2 on row 2, first window at (2,2)
        n0 = n_win[1];
        for (int k = 0; k < 10; k++) cyc(1, 1'b1, k == 0, 8'(k + 1));
        cyc(1, 1'b1, 1'b0, 8'd11);
        chk("c5_en_x0", int'(en5), 0);
        cyc(1, 1'b1, 1'b0, 8'd12);
        chk("c5_en_x1", int'(en5), 0);
        cyc(1, 1'b1, 1'b0, 8'd13);
        chk("c5_en_x2", int'(en5), 1);
        chk("c5_data_2_0", outp(1, 6), 11);
        for (int k = 13; k < 25; k++) cyc(1, 1'b1, 1'b0, 8'(k + 1));
        idle(1, 2);
`ifdef CONV33_WIN_STRIDE2_EN
        chk("s2_window_count", got_d00_5.size(), 4);
        if (got_d00_5.size() == 4) begin
            chk("s2_d00_0", got_d00_5[0], 1);
            chk("s2_d00_1", got_d00_5[1], 3);
            chk("s2_d00_2", got_d00_5[2], 11);
            chk("s2_d00_3", got_d00_5[3], 13);
        end
`else
        chk("c5_window_count", n_win[1] - n0, 9);
`endif

        // Abort at pixel (3,1) with sof, then a full new frame
        n0 = n_win[0];
        nd = n_done[0];
        for (int k = 0; k < 13; k++) cyc(0, 1'b1, k == 0, 8'(k + 1));
        for (int j = 0; j < 16; j++) cyc(0, 1'b1, j == 0, 8'(101 + j));
        idle(0, 2);
        chk("abort_window_count", n_win[0] - n0, 6);
        chk("abort_done_count", n_done[0] - nd, 1);

        // Reset during RUN, then pixels without sof are ignored
        for (int k = 0; k < 12; k++) cyc(0, 1'b1, k == 0, 8'(k + 1));
        do_rst(0);
        for (int k = 0; k < 6; k++) cyc(0, 1'b1, 1'b0, 8'(50 + k));
        chk("post_rst_busy", int'(busy4), 0);
        idle(0, 1);
        n0 = n_win[0];
        for (int k = 0; k < 16; k++) cyc(0, 1'b1, k == 0, 8'(k + 21));
        idle(0, 2);
        chk("post_rst_window_count", n_win[0] - n0, 4);

        chk("scoreboard_empty", q0.size() + q1.size(), 0);
        mon_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
